elastic_fifo: RTL and testbench



---
 rtl/util_pkg.sv | 18 +
 rtl/ring_ptr.sv | 25 ++
 rtl/elastic_fifo.sv | 103 ++++++++++
 tb/tb_elastic_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_pkg.sv
// Shared helpers for the core's queues: occupancy type, pointer sizing and
// the push/pop operation decode.
package util_pkg;

  typedef logic [31:0] fifo_cnt_t;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// Wrap-around pointer register: async reset, synchronous clear (priority) and
// increment enable. Wraps naturally at 2**W.
module ring_ptr #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/elastic_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, synchronous
// flush and an explicitly maintained occupancy counter.
module elastic_fifo
  import util_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned   PW       = ptr_width(DEPTH);
  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;
  logic             push;
  logic             pop;
  fifo_op_e         op;

  // Status comes purely from the registered count: no input-to-output path.
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;
  assign op   = fifo_op_e'({push, pop});

  ring_ptr #(.W(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (push),
    .ptr (wr_ptr)
  );

  ring_ptr #(.W(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .inc (pop),
    .ptr (rd_ptr)
  );

  // NOTE: the storage array has no reset; out_data is masked while empty, so
  // power-up contents are never observable and the array stays plain flops.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      case (op)
        OP_PUSH: count_q <= count_q + CW'(1);
        OP_POP:  count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the default assignment comes first so no path leaves out_data
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = mem[rd_ptr];
    end
  end

  logic [PW-1:0] ptr_diff;
  assign ptr_diff = wr_ptr - rd_ptr;

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_cnt_t'(count_q) <= fifo_cnt_t'(DEPTH));

  // A full ring has coincident pointers; otherwise the distance is the count.
  a_count_ptrs: assert property (@(posedge clk) disable iff (rst)
    (count_q == FULL_CNT) ? (wr_ptr == rd_ptr) : (ptr_diff == count_q[PW-1:0]));

endmodule

// File: tb/tb_elastic_fifo.sv
// Self-checking bench for elastic_fifo: directed scenarios plus a random run,
// all compared against a queue-based model of the FIFO rules.
module tb_elastic_fifo;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] model[$];

  elastic_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // Advance one clock edge and apply the FIFO rules to the model.
  task automatic tick();
    bit do_push;
    bit do_pop;
    logic [WIDTH-1:0] d;
    do_push = in_valid && (model.size() < DEPTH);
    do_pop  = out_ready && (model.size() > 0);
    d       = in_data;
    @(posedge clk);
    #1;
    if (flush) begin
      model.delete();
    end else begin
      if (do_pop) void'(model.pop_front());
      if (do_push) model.push_back(d);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_head();
    return (model.size() > 0) ? model[0] : '0;
  endfunction

  task automatic test_reset();
    #1;
    checks++;
    if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1 ||
        out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_init: count=%0d empty=%b full=%b in_ready=%b out_valid=%b out_data=%h, want 0 1 0 1 0 0",
               count, empty, full, in_ready, out_valid, out_data);
    end
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'h1111_0001;
    tick();
    in_data  = 32'h1111_0002;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== CW'(2) || out_data !== 32'h1111_0001) begin
      errors++;
      $display("FAIL reset_pre: count=%0d out_data=%h, want 2 11110001", count, out_data);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if (count !== '0 || empty !== 1'b1 || in_ready !== 1'b1 || out_valid !== 1'b0 ||
        out_data !== '0 || full !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: count=%0d empty=%b in_ready=%b out_valid=%b out_data=%h, want 0 1 1 0 0",
               count, empty, in_ready, out_valid, out_data);
    end
    model.delete();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_drain();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = 32'hA0 + i;
      tick();
    end
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== CW'(4)) begin
      errors++;
      $display("FAIL fill_full: full=%b in_ready=%b count=%0d, want 1 0 4", full, in_ready, count);
    end
    in_data = 32'hA4;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== CW'(4) || out_data !== 32'hA0 || model.size() != 4) begin
      errors++;
      $display("FAIL fill_refuse: count=%0d head=%h, want 4 a0", count, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'hA0 + i) begin
        errors++;
        $display("FAIL drain_%0d: valid=%b data=%h, want 1 %h", i, out_valid, out_data, 32'hA0 + i);
      end
      tick();
    end
    out_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || out_valid !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b valid=%b data=%h, want 1 0 0", empty, out_valid, out_data);
    end
  endtask

  task automatic test_streaming();
    logic [WIDTH-1:0] prev;
    int bad = 0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = $urandom;
      prev    = in_data;
      tick();
      if (count !== CW'(1) || out_valid !== 1'b1 || out_data !== prev) bad++;
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    checks++;
    if (bad != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL streaming: bad_cycles=%0d empty=%b, want 0 1", bad, empty);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hB000 + i;
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (out_data !== model_head()) bad++;
      in_data = 32'hC000 + i;
      tick();
      if (count !== CW'(3) || out_data !== model_head()) bad++;
    end
    checks++;
    if (bad != 0 || count !== CW'(3) || out_data !== 32'hC000 + 8) begin
      errors++;
      $display("FAIL wrap: bad=%0d count=%0d head=%h, want 0 3 %h", bad, count, out_data, 32'hC000 + 8);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    in_valid = 1'b1;
    in_data  = 32'hD0;
    tick();
    checks++;
    if (count !== CW'(4) || full !== 1'b1) begin
      errors++;
      $display("FAIL fullpop_pre: count=%0d full=%b, want 4 1", count, full);
    end
    in_data   = 32'hD1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (count !== CW'(3) || in_ready !== 1'b1 || out_data !== model_head()) begin
      errors++;
      $display("FAIL fullpop_one: count=%0d in_ready=%b head=%h, want 3 1 %h",
               count, in_ready, out_data, model_head());
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== CW'(4) || model[3] !== 32'hD1) begin
      errors++;
      $display("FAIL fullpop_held: count=%0d, want 4 with d1 at tail", count);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    tick();
    checks++;
    if (count !== CW'(3)) begin
      errors++;
      $display("FAIL flush_pre: count=%0d, want 3", count);
    end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h55;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || out_data !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL flush_clear: count=%0d valid=%b data=%h, want 0 0 0", count, out_valid, out_data);
    end
    in_data = 32'h66;
    tick();
    in_valid = 1'b0;
    checks++;
    if (count !== CW'(1) || out_valid !== 1'b1 || out_data !== 32'h66) begin
      errors++;
      $display("FAIL flush_after: count=%0d valid=%b data=%h, want 1 1 66", count, out_valid, out_data);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (empty !== 1'b1 || out_data !== '0) begin
      errors++;
      $display("FAIL flush_residue: empty=%b data=%h, want 1 0", empty, out_data);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_data   = $urandom;
      tick();
      if (count !== CW'(model.size()) || full !== (model.size() == DEPTH) ||
          empty !== (model.size() == 0) || in_ready !== (model.size() != DEPTH) ||
          out_valid !== (model.size() != 0) || out_data !== model_head()) begin
        bad++;
        if (bad <= 5)
          $display("FAIL random_cyc%0d: count=%0d data=%h, want %0d %h",
                   i, count, out_data, model.size(), model_head());
      end
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random: bad_cycles=%0d, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_streaming();
    test_wrap();
    test_full_pop();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
